running_man_ctrl: RTL

Frame-sequencing controller for the running-man pixel datapath. It sits between the keyboard/key inputs and the datapath, and sequences the whole frame loop: one-time floor draw, then per frame draw man → hold → erase man → physics update. It owns the man's vertical position, jump velocity and crouch style, and loads them into the datapath through the `ld_*` strobes.

---
 rtl/running_man_pkg.sv | 23 ++
 rtl/running_man_ctrl_frame_timer.sv | 27 ++
 rtl/running_man_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/running_man_pkg.sv
// Shared constants for the running-man controller: state encodings, man geometry
// and floor rows.
package running_man_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_FLOORS = 3'd0;
  localparam state_t S_LOAD   = 3'd1;
  localparam state_t S_DRAW   = 3'd2;
  localparam state_t S_HOLD   = 3'd3;
  localparam state_t S_ERASE  = 3'd4;
  localparam state_t S_UPDATE = 3'd5;

  localparam logic [7:0]        X_POS    = 8'd30;
  localparam logic [6:0]        GROUND_Y = 7'd108;
  localparam logic [6:0]        CEIL_Y   = 7'd80;
  localparam logic signed [4:0] JUMP_V   = 5'sd6;

  localparam logic [6:0] FLOOR_TOP_ROW = 7'd35;
  localparam logic [6:0] FLOOR_MID_ROW = 7'd75;
  localparam logic [6:0] FLOOR_BOT_ROW = 7'd115;

endpackage

// File: rtl/running_man_ctrl_frame_timer.sv
// Frame hold counter: counts enabled cycles and pulses done on the last one
// of every FRAME_CYCLES-long window.
module frame_timer #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(FRAME_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n || clear)
      count <= '0;
    else if (enable)
      count <= (count == LAST) ? '0 : count + 1'b1;
  end

  assign done = enable && (count == LAST);

endmodule

// File: rtl/running_man_ctrl.sv
// Frame sequencer for the running-man datapath: floors once, then draw/hold/erase/update.
// Crouch support is compiled in only when RUNNING_MAN_CROUCH_EN is defined.
module running_man_ctrl
  import running_man_pkg::*;
#(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       jump,
  input  logic       crouch,
  input  logic       draw_floors_finish,
  input  logic       draw_man_finish,
  input  logic       erase_finish,
  output logic       drawing_floors,
  output logic       draw_man,
  output logic       erase,
  output logic       plot,
  output logic       ld_x,
  output logic       ld_y,
  output logic       ld_man_style,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic       man_style
);

  state_t            state, state_next;
  logic [6:0]        y_reg, y_next;
  logic signed [4:0] vel_reg, vel_next, vel_inc;
  logic signed [7:0] y_sum;
  logic              style_reg, style_next;
  logic              grounded;
  logic              hold_done;

  frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   ((state == S_DRAW) && draw_man_finish),
    .enable  (state == S_HOLD),
    .done    (hold_done)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_FLOORS: if (draw_floors_finish) state_next = S_LOAD;
      S_LOAD:   state_next = S_DRAW;
      S_DRAW:   if (draw_man_finish) state_next = S_HOLD;
      S_HOLD:   if (hold_done) state_next = S_ERASE;
      S_ERASE:  if (erase_finish) state_next = S_UPDATE;
      S_UPDATE: state_next = S_DRAW;
      default:  state_next = S_FLOORS;
    endcase
  end

  // Velocity steps before position, so an airborne frame moves by the new speed.
  always_comb begin
    grounded   = (y_reg == GROUND_Y) && (vel_reg == 5'sd0);
    vel_inc    = vel_reg + 5'sd1;
    y_sum      = $signed({1'b0, y_reg}) + $signed({{3{vel_inc[4]}}, vel_inc});
    y_next     = y_reg;
    vel_next   = vel_reg;
    style_next = 1'b1;
    if (grounded && jump) begin
      vel_next = -JUMP_V;
      y_next   = y_reg - 7'(JUMP_V);
    end else if (!grounded) begin
      vel_next = vel_inc;
      if (y_sum >= $signed({1'b0, GROUND_Y})) begin
        y_next   = GROUND_Y;
        vel_next = 5'sd0;
      end else if (y_sum < $signed({1'b0, CEIL_Y})) begin
        y_next = CEIL_Y;
      end else begin
        y_next = y_sum[6:0];
      end
    end
`ifdef RUNNING_MAN_CROUCH_EN
    style_next = !(grounded && crouch && !jump);
`endif
  end

`ifndef RUNNING_MAN_CROUCH_EN
  logic unused_crouch;
  assign unused_crouch = crouch;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_FLOORS;
      y_reg     <= GROUND_Y;
      vel_reg   <= 5'sd0;
      style_reg <= 1'b1;
    end else begin
      state <= state_next;
      if (state == S_LOAD) begin
        y_reg     <= GROUND_Y;
        vel_reg   <= 5'sd0;
        style_reg <= 1'b1;
      end else if (state == S_UPDATE) begin
        y_reg     <= y_next;
        vel_reg   <= vel_next;
        style_reg <= style_next;
      end
    end
  end

  assign drawing_floors = (state == S_FLOORS);
  assign draw_man       = (state == S_DRAW);
  assign erase          = (state == S_ERASE);
  assign plot           = drawing_floors | draw_man | erase;
  assign ld_x           = (state == S_LOAD) || (state == S_UPDATE);
  assign ld_y           = ld_x;
  assign ld_man_style   = ld_x;
  assign x_out          = X_POS;
  assign y_out          = y_reg;
  assign man_style      = style_reg;

endmodule
